// File: rtl/id_glue_pkg.sv
// Shared constants for the instruction-decode glue block.
//   DEC_IDLE      : decoder output pattern when disabled or in reset
//   BUS_RST_FILL  : per-bit reset value of the registered bus output
//   MUX_RST_FILL  : per-bit reset value of the registered mux output
//   W_DEFAULT     : default data width of the bus and the mux
package id_glue_pkg;

  localparam int         W_DEFAULT    = 32;
  localparam logic [7:0] DEC_IDLE     = 8'hFF;

  // Single-bit fills are replicated to the instance width, so the reset
  // values stay correct for any W without width truncation.
  localparam logic       BUS_RST_FILL = 1'b0;
  localparam logic       MUX_RST_FILL = 1'b0;

endpackage

// File: rtl/onehot_bus_sel.sv
// Combinational model of an N-source bus with active-low drive enables.
//   oe_n     in  NSRC    per-source drive enables, active low
//   data     in  NSRC*W  source k occupies bits [k*W +: W]
//   sel      out W       driven value (0 when nobody drives)
//   conflict out 1       more than one enable is low
// With several drivers the lowest-index active source wins.
module onehot_bus_sel #(
  parameter int NSRC = 3,
  parameter int W    = 32
) (
  input  logic [NSRC-1:0]   oe_n,
  input  logic [NSRC*W-1:0] data,
  output logic [W-1:0]      sel,
  output logic              conflict
);

  logic found;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update;
    // a path that leaves a combinational output unassigned infers a latch.
    sel      = '0;
    conflict = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (!oe_n[i]) begin
        if (found) begin
          conflict = 1'b1;
        end else begin
          sel   = data[i*W +: W];
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_glue_reg.sv
// Registered decode-stage glue: 74x138-style decoder, active-low one-hot bus
// and 2:1 mux, all captured in one output register stage (1-cycle latency).
//   clk, rst                       clock, synchronous active-high reset
//   dec_a, dec_g1, dec_g2a_n,
//   dec_g2b_n -> dec_y_n           decoder select/enables, active-low outputs
//   bus_oe_n, bus_data
//     -> bus_out, bus_conflict     bus enables/data, selected value, conflict
//   mux_a, mux_b, mux_s -> mux_y   mux inputs, select-low-picks-A
module id_glue_reg
  import id_glue_pkg::*;
#(
  parameter int NSRC = 3,
  parameter int W    = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        dec_a,
  input  logic              dec_g1,
  input  logic              dec_g2a_n,
  input  logic              dec_g2b_n,
  output logic [7:0]        dec_y_n,
  input  logic [NSRC-1:0]   bus_oe_n,
  input  logic [NSRC*W-1:0] bus_data,
  output logic [W-1:0]      bus_out,
  output logic              bus_conflict,
  input  logic [W-1:0]      mux_a,
  input  logic [W-1:0]      mux_b,
  input  logic              mux_s,
  output logic [W-1:0]      mux_y
);

  logic [7:0]   dec_next;
  logic [W-1:0] bus_next;
  logic         conflict_next;
  logic [W-1:0] mux_next;

  // Decoder: one output pulled low only when all three enables agree.
  always_comb begin
    dec_next = DEC_IDLE;
    if (dec_g1 && !dec_g2a_n && !dec_g2b_n) begin
      dec_next[dec_a] = 1'b0;
    end
  end

  // Bus selection.
  onehot_bus_sel #(
    .NSRC (NSRC),
    .W    (W)
  ) u_bus_sel (
    .oe_n     (bus_oe_n),
    .data     (bus_data),
    .sel      (bus_next),
    .conflict (conflict_next)
  );

  // Mux.
  always_comb begin
    mux_next = mux_s ? mux_b : mux_a;
  end

  // Shared output register stage; reset wins over every live input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      dec_y_n      <= DEC_IDLE;
      bus_out      <= {W{BUS_RST_FILL}};
      bus_conflict <= 1'b0;
      mux_y        <= {W{MUX_RST_FILL}};
    end else begin
      dec_y_n      <= dec_next;
      bus_out      <= bus_next;
      bus_conflict <= conflict_next;
      mux_y        <= mux_next;
    end
  end

endmodule

// File: tb/tb_id_glue_reg.sv
// Self-checking bench for id_glue_reg (NSRC=3, W=32). Stimulus is applied on
// the falling edge and the expected register contents for the following
// rising edge are queued; a monitor pops and compares just after each edge.
module tb_id_glue_reg;

  localparam int NSRC = 3;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        dec_a;
  logic              dec_g1, dec_g2a_n, dec_g2b_n;
  logic [7:0]        dec_y_n;
  logic [NSRC-1:0]   bus_oe_n;
  logic [NSRC*W-1:0] bus_data;
  logic [W-1:0]      bus_out;
  logic              bus_conflict;
  logic [W-1:0]      mux_a, mux_b;
  logic              mux_s;
  logic [W-1:0]      mux_y;

  typedef struct {
    string      name;
    logic [7:0] dec;
    logic [31:0] bus;
    logic       conf;
    logic [31:0] mux;
  } exp_t;

  exp_t q[$];
  int   n_vectors     = 0;
  int   n_miscompares = 0;

  always #5 clk = ~clk;

  id_glue_reg #(.NSRC(NSRC), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_a        (dec_a),
    .dec_g1       (dec_g1),
    .dec_g2a_n    (dec_g2a_n),
    .dec_g2b_n    (dec_g2b_n),
    .dec_y_n      (dec_y_n),
    .bus_oe_n     (bus_oe_n),
    .bus_data     (bus_data),
    .bus_out      (bus_out),
    .bus_conflict (bus_conflict),
    .mux_a        (mux_a),
    .mux_b        (mux_b),
    .mux_s        (mux_s),
    .mux_y        (mux_y)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, so compare whenever an
  // expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vectors++;
        check({e.name, ".dec_y_n"},      {24'd0, dec_y_n},      {24'd0, e.dec});
        check({e.name, ".bus_out"},      bus_out,               e.bus);
        check({e.name, ".bus_conflict"}, {31'd0, bus_conflict}, {31'd0, e.conf});
        check({e.name, ".mux_y"},        mux_y,                 e.mux);
      end
    end
  end

  task automatic apply(input string name, input logic r,
                       input logic [2:0] a, input logic g1, input logic g2a, input logic g2b,
                       input logic [2:0] oe, input logic [31:0] ma, input logic [31:0] mb,
                       input logic s,
                       input logic [7:0] x_dec, input logic [31:0] x_bus,
                       input logic x_conf, input logic [31:0] x_mux);
    exp_t e;
    @(negedge clk);
    rst = r; dec_a = a; dec_g1 = g1; dec_g2a_n = g2a; dec_g2b_n = g2b;
    bus_oe_n = oe; mux_a = ma; mux_b = mb; mux_s = s;
    e.name = name; e.dec = x_dec; e.bus = x_bus; e.conf = x_conf; e.mux = x_mux;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dec_tab [8];
    dec_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    rst      = 1'b1;
    bus_data = {32'hAAAA0000, 32'h0000BBBB, 32'h12345678};
    dec_a = 3'd0; dec_g1 = 1'b0; dec_g2a_n = 1'b1; dec_g2b_n = 1'b1;
    bus_oe_n = 3'b111; mux_a = '0; mux_b = '0; mux_s = 1'b0;

    // Reset held for two edges with random live inputs.
    for (int i = 0; i < 2; i++)
      apply("reset", 1'b1, 3'($urandom), 1'b1, 1'b0, 1'b0, 3'($urandom),
            $urandom, $urandom, 1'($urandom), 8'hFF, 32'h0, 1'b0, 32'h0);

    // Decoder sweep, fully enabled.
    for (int i = 0; i < 8; i++)
      apply($sformatf("dec_a%0d", i), 1'b0, 3'(i), 1'b1, 1'b0, 1'b0, 3'b111,
            32'h0, 32'h0, 1'b0, dec_tab[i], 32'h0, 1'b0, 32'h0);
    apply("dec_g2a_off", 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 3'b111,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h0, 1'b0, 32'h0);
    apply("dec_g1_off",  1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 3'b111,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h0, 1'b0, 32'h0);
    apply("dec_g2b_off", 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 3'b111,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h0, 1'b0, 32'h0);

    // Bus: one-hot, none, and multiple drivers.
    apply("bus_src0",   1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b110,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h12345678, 1'b0, 32'h0);
    apply("bus_src2",   1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b011,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'hAAAA0000, 1'b0, 32'h0);
    apply("bus_src1",   1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b101,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h0000BBBB, 1'b0, 32'h0);
    apply("bus_none",   1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b111,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h0, 1'b0, 32'h0);
    apply("bus_c01",    1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b100,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h12345678, 1'b1, 32'h0);
    apply("bus_c12",    1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b001,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h0000BBBB, 1'b1, 32'h0);
    apply("bus_all",    1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b000,
          32'h0, 32'h0, 1'b0, 8'hFF, 32'h12345678, 1'b1, 32'h0);

    // Mux, then toggling select with 1-cycle lag.
    apply("mux_s0", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b111,
          32'h4, 32'hFFFFF800, 1'b0, 8'hFF, 32'h0, 1'b0, 32'h4);
    apply("mux_s1", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b111,
          32'h4, 32'hFFFFF800, 1'b1, 8'hFF, 32'h0, 1'b0, 32'hFFFFF800);
    for (int i = 0; i < 6; i++)
      apply($sformatf("mux_tog%0d", i), 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'b111,
            32'h4, 32'hFFFFF800, 1'(i), 8'hFF, 32'h0, 1'b0,
            (i % 2 == 1) ? 32'hFFFFF800 : 32'h4);

    // Reset mid-stream: active inputs, one reset edge, then recapture.
    apply("mid_live", 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 3'b100,
          32'h4, 32'hFFFFF800, 1'b1, 8'hF7, 32'h12345678, 1'b1, 32'hFFFFF800);
    apply("mid_rst",  1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 3'b100,
          32'h4, 32'hFFFFF800, 1'b1, 8'hFF, 32'h0, 1'b0, 32'h0);
    apply("mid_rec",  1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 3'b100,
          32'h4, 32'hFFFFF800, 1'b1, 8'hBF, 32'h12345678, 1'b1, 32'hFFFFF800);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
